// File: rtl/alarm_clock_core.sv
// alarm_clock_core
// Time-of-day keeper (HH:MM, 24 h) with a time editor, an alarm editor and a
// ringing led. It consumes single-cycle command pulses from the button-control
// block and feeds registered HH:MM, mode and alarm status to the display driver.
//
// Command pulse protocol: every semnal_* input is a one-cycle, already
// debounced pulse. It is sampled on the rising clock edge where it is high. It
// needs no acknowledge, and it cannot be held off. Pulses that are not legal
// in the current state are dropped. When several pulses arrive in one cycle
// they resolve as stop > setare > setare_a > b1/b2. b1 and b2 together both
// apply. A stop pulse outside RINGING disarms the alarm and masks the other
// pulses of that cycle.
//
// The mode output is the FSM state register itself, so checkers can bind to it.

module alarm_clock_core #(
    parameter int TICKS_PER_MIN = 60000000,
    parameter int BLINK_TICKS   = 12500000,
    parameter int RING_TICKS    = 1800000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       semnal_setare,
    input  logic       semnal_setare_a,
    input  logic       semnal_b1,
    input  logic       semnal_b2,
    input  logic       semnal_stop,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic [1:0] mode,
    output logic       alarm_on,
    output logic       led
);

    // Counter widths; each one is at least 1 bit, even for degenerate parameter values.
    localparam int TICK_W  = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int BLINK_W = (BLINK_TICKS   > 2) ? $clog2(BLINK_TICKS)   : 1;
    localparam int RING_W  = (RING_TICKS    > 2) ? $clog2(RING_TICKS)    : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_MIN - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(RING_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_SET_ALARM = 2'b10,
        ST_RINGING   = 2'b11
    } state_t;

    state_t             state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [RING_W-1:0]  ring_cnt;
    logic [4:0]         time_h;
    logic [5:0]         time_m;
    logic [4:0]         alarm_h;
    logic [5:0]         alarm_m;

    state_t             nxt_state;
    logic [TICK_W-1:0]  nxt_tick;
    logic [BLINK_W-1:0] nxt_blink;
    logic [RING_W-1:0]  nxt_ring;
    logic [4:0]         nxt_time_h;
    logic [5:0]         nxt_time_m;
    logic [4:0]         nxt_alarm_h;
    logic [5:0]         nxt_alarm_m;
    logic               nxt_alarm_on;
    logic               nxt_led;
    logic               tick_wrap;
    logic               ring_hit;

    // Hours step 23 -> 0.
    function automatic logic [4:0] inc_hour(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minutes step 59 -> 0; any carry into the hours is the caller's job.
    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    assign mode = state;

    // Next-state logic: timebase, minute rollover, alarm match, and the command FSM.
    always_comb begin
        nxt_state    = state;
        nxt_tick     = tick_cnt;
        nxt_blink    = blink_cnt;
        nxt_ring     = ring_cnt;
        nxt_time_h   = time_h;
        nxt_time_m   = time_m;
        nxt_alarm_h  = alarm_h;
        nxt_alarm_m  = alarm_m;
        nxt_alarm_on = alarm_on;
        nxt_led      = led;
        tick_wrap    = 1'b0;
        ring_hit     = 1'b0;

        // The timebase is frozen at zero while the time is being edited, so a
        // freshly set time always gets a full minute before its first step.
        if (state == ST_SET_TIME) begin
            nxt_tick = '0;
        end else if (tick_cnt == TICK_LAST) begin
            nxt_tick  = '0;
            tick_wrap = 1'b1;
        end else begin
            nxt_tick = tick_cnt + TICK_W'(1);
        end

        if (tick_wrap) begin
            nxt_time_m = inc_min(time_m);
            if (time_m == 6'd59) begin
                nxt_time_h = inc_hour(time_h);
            end
        end

        // The alarm fires only on the edge that rolls the clock into the alarm
        // minute, so setting the time directly onto the alarm stays silent.
        ring_hit = tick_wrap && alarm_on &&
                   (nxt_time_h == alarm_h) && (nxt_time_m == alarm_m);

        case (state)
            ST_RUN: begin
                if (semnal_stop) begin
                    nxt_alarm_on = 1'b0;
                end else if (semnal_setare) begin
                    nxt_state = ST_SET_TIME;
                end else if (semnal_setare_a) begin
                    nxt_state = ST_SET_ALARM;
                end else if (ring_hit) begin
                    nxt_state = ST_RINGING;
                    nxt_led   = 1'b1;
                    nxt_blink = '0;
                    nxt_ring  = '0;
                end
            end

            ST_SET_TIME: begin
                if (semnal_stop) begin
                    nxt_alarm_on = 1'b0;
                end else if (semnal_setare) begin
                    nxt_state = ST_RUN;
                end else begin
                    if (semnal_b1) begin
                        nxt_time_h = inc_hour(time_h);
                    end
                    if (semnal_b2) begin
                        nxt_time_m = inc_min(time_m);
                    end
                end
            end

            ST_SET_ALARM: begin
                if (semnal_stop) begin
                    nxt_alarm_on = 1'b0;
                end else if (semnal_setare_a) begin
                    nxt_state    = ST_RUN;
                    nxt_alarm_on = 1'b1;
                end else begin
                    if (semnal_b1) begin
                        nxt_alarm_h = inc_hour(alarm_h);
                    end
                    if (semnal_b2) begin
                        nxt_alarm_m = inc_min(alarm_m);
                    end
                end
            end

            ST_RINGING: begin
                // The alarm stays armed on either exit, so it rings again the next day.
                if (semnal_stop || (ring_cnt == RING_LAST)) begin
                    nxt_state = ST_RUN;
                    nxt_led   = 1'b0;
                    nxt_blink = '0;
                    nxt_ring  = '0;
                end else begin
                    nxt_ring = ring_cnt + RING_W'(1);
                    if (blink_cnt == BLINK_LAST) begin
                        nxt_blink = '0;
                        nxt_led   = ~led;
                    end else begin
                        nxt_blink = blink_cnt + BLINK_W'(1);
                    end
                end
            end

            default: begin
                nxt_state = ST_RUN;
            end
        endcase
    end

    // State and output registers; the display mux is taken from next-state values so it is registered too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_RUN;
            tick_cnt     <= '0;
            blink_cnt    <= '0;
            ring_cnt     <= '0;
            time_h       <= 5'd0;
            time_m       <= 6'd0;
            alarm_h      <= 5'd0;
            alarm_m      <= 6'd0;
            alarm_on     <= 1'b0;
            led          <= 1'b0;
            disp_hours   <= 5'd0;
            disp_minutes <= 6'd0;
        end else begin
            state        <= nxt_state;
            tick_cnt     <= nxt_tick;
            blink_cnt    <= nxt_blink;
            ring_cnt     <= nxt_ring;
            time_h       <= nxt_time_h;
            time_m       <= nxt_time_m;
            alarm_h      <= nxt_alarm_h;
            alarm_m      <= nxt_alarm_m;
            alarm_on     <= nxt_alarm_on;
            led          <= nxt_led;
            disp_hours   <= (nxt_state == ST_SET_ALARM) ? nxt_alarm_h : nxt_time_h;
            disp_minutes <= (nxt_state == ST_SET_ALARM) ? nxt_alarm_m : nxt_time_m;
        end
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Testbench for alarm_clock_core with small timing parameters.
// The reference model keeps the time and the alarm as minutes-of-day.
// It keeps the ringing as an age in cycles, and it derives the led from that age.

module tb_alarm_clock_core;

    localparam int TPM        = 4;
    localparam int BLINK      = 2;
    localparam int RING       = 16;
    localparam int DAY_CYCLES = TPM * 60 * 24;

    // ---------------- clock / reset / DUT ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       semnal_setare = 1'b0;
    logic       semnal_setare_a = 1'b0;
    logic       semnal_b1 = 1'b0;
    logic       semnal_b2 = 1'b0;
    logic       semnal_stop = 1'b0;
    logic [4:0] disp_hours;
    logic [5:0] disp_minutes;
    logic [1:0] mode;
    logic       alarm_on;
    logic       led;

    always #5 clock = ~clock;

    alarm_clock_core #(
        .TICKS_PER_MIN(TPM),
        .BLINK_TICKS  (BLINK),
        .RING_TICKS   (RING)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .semnal_setare  (semnal_setare),
        .semnal_setare_a(semnal_setare_a),
        .semnal_b1      (semnal_b1),
        .semnal_b2      (semnal_b2),
        .semnal_stop    (semnal_stop),
        .disp_hours     (disp_hours),
        .disp_minutes   (disp_minutes),
        .mode           (mode),
        .alarm_on       (alarm_on),
        .led            (led)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] exp_q[$];

    // reference model state
    int m_time;      // minutes since midnight
    int m_alarm;     // minutes since midnight
    int m_phase;     // cycles elapsed in the current minute
    int m_mode;      // 0 run, 1 set time, 2 set alarm, 3 ringing
    bit m_armed;
    int m_ring_age;  // cycles spent ringing

    function automatic logic [14:0] pack(input int h, input int m, input int md,
                                         input bit on, input bit ld);
        return {5'(h), 6'(m), 2'(md), on, ld};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {disp_hours, disp_minutes, mode, alarm_on, led};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_time     = 0;
        m_alarm    = 0;
        m_phase    = 0;
        m_mode     = 0;
        m_armed    = 1'b0;
        m_ring_age = 0;
        exp_q.delete();
    endtask

    // One rising edge of the reference model; pushes the expected outputs after it.
    task automatic model_step(input bit stp, input bit st, input bit sta,
                              input bit bb1, input bit bb2);
        int  nt;
        bit  wrap;
        int  shown;
        bit  exp_led;
        nt   = m_time;
        wrap = 1'b0;
        if (m_mode == 1) begin
            m_phase = 0;
        end else if (m_phase == TPM - 1) begin
            m_phase = 0;
            wrap    = 1'b1;
            nt      = (m_time + 1) % 1440;
        end else begin
            m_phase = m_phase + 1;
        end
        case (m_mode)
            0: begin
                if (stp) m_armed = 1'b0;
                else if (st) m_mode = 1;
                else if (sta) m_mode = 2;
                else if (wrap && m_armed && nt == m_alarm) begin
                    m_mode     = 3;
                    m_ring_age = 0;
                end
            end
            1: begin
                if (stp) m_armed = 1'b0;
                else if (st) m_mode = 0;
                else begin
                    if (bb1) nt = ((nt / 60 + 1) % 24) * 60 + nt % 60;
                    if (bb2) nt = (nt / 60) * 60 + (nt % 60 + 1) % 60;
                end
            end
            2: begin
                if (stp) m_armed = 1'b0;
                else if (sta) begin
                    m_mode  = 0;
                    m_armed = 1'b1;
                end else begin
                    if (bb1) m_alarm = ((m_alarm / 60 + 1) % 24) * 60 + m_alarm % 60;
                    if (bb2) m_alarm = (m_alarm / 60) * 60 + (m_alarm % 60 + 1) % 60;
                end
            end
            default: begin
                if (stp || m_ring_age == RING - 1) m_mode = 0;
                else m_ring_age = m_ring_age + 1;
            end
        endcase
        m_time  = nt;
        shown   = (m_mode == 2) ? m_alarm : m_time;
        exp_led = (m_mode == 3) && ((m_ring_age / BLINK) % 2 == 0);
        exp_q.push_back(pack(shown / 60, shown % 60, m_mode, m_armed, exp_led));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit stp, input bit st, input bit sta,
                         input bit bb1, input bit bb2);
        semnal_stop     = stp;
        semnal_setare   = st;
        semnal_setare_a = sta;
        semnal_b1       = bb1;
        semnal_b2       = bb2;
        @(posedge clock);
        model_step(stp, st, sta, bb1, bb2);
        #1;
        semnal_stop     = 1'b0;
        semnal_setare   = 1'b0;
        semnal_setare_a = 1'b0;
        semnal_b1       = 1'b0;
        semnal_b2       = 1'b0;
        check("cycle", dut_outs(), exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_time_to(input int h, input int m);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24 && (m_time / 60) != h; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60 && (m_time % 60) != m; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("set_time_value", {disp_hours, disp_minutes}, {5'(h), 6'(m)});
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_ring(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            idle(1);
            if (mode == 2'b11) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
    endtask

    // Reset pulse placed between clock edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check(tag, dut_outs(), pack(0, 0, 0, 1'b0, 1'b0));
        model_reset();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ring_len;
        model_reset();
        #2;
        check("reset_state", dut_outs(), pack(0, 0, 0, 1'b0, 1'b0));
        #1;
        reset = 1'b1;

        // full day of free running
        for (int k = 1; k <= DAY_CYCLES; k++) begin
            idle(1);
            if (k == 4)          check("t1_first_minute", dut_outs(), pack(0, 1, 0, 1'b0, 1'b0));
            if (k == 236)        check("t1_0059", dut_outs(), pack(0, 59, 0, 1'b0, 1'b0));
            if (k == 240)        check("t1_0100", dut_outs(), pack(1, 0, 0, 1'b0, 1'b0));
            if (k == DAY_CYCLES - 4) check("t1_2359", dut_outs(), pack(23, 59, 0, 1'b0, 1'b0));
            if (k == DAY_CYCLES) check("t1_day_wrap", dut_outs(), pack(0, 0, 0, 1'b0, 1'b0));
        end

        // time edit with wrap of both fields
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_mode_set", mode, 2'b01);
        repeat (25) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (61) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_edited", dut_outs(), pack(1, 1, 1, 1'b0, 1'b0));
        idle(9);
        check("t2_frozen", dut_outs(), pack(1, 1, 1, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_exit", dut_outs(), pack(1, 1, 0, 1'b0, 1'b0));
        idle(3);
        check("t2_before_step", dut_outs(), pack(1, 1, 0, 1'b0, 1'b0));
        idle(1);
        check("t2_step", dut_outs(), pack(1, 2, 0, 1'b0, 1'b0));

        // alarm edit, ring, stop
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_alarm_view", dut_outs(), pack(0, 0, 2, 1'b0, 1'b0));
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_alarm_edit", {disp_hours, disp_minutes}, {5'd0, 6'd2});
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_armed", {mode, alarm_on}, {2'b00, 1'b1});
        set_time_to(0, 1);
        wait_ring("t3_ring_seen", 8);
        check("t3_ring_entry", dut_outs(), pack(0, 2, 3, 1'b1, 1'b1));
        idle(1);
        check("t3_led_second", led, 1'b1);
        idle(1);
        check("t3_led_third", led, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_stopped", dut_outs(), pack(0, 2, 0, 1'b1, 1'b0));

        // next day, let it time out
        wait_ring("t4_ring_seen", DAY_CYCLES + 8);
        ring_len = 1;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (mode == 2'b11) ring_len++;
            else break;
        end
        check("t4_ring_len", ring_len, RING);
        check("t4_after_timeout", {mode, alarm_on, led}, {2'b00, 1'b1, 1'b0});
        wait_ring("t4_ring_again", DAY_CYCLES + 8);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset while ringing
        set_time_to(0, 1);
        wait_ring("t6_ring_seen", 8);
        async_reset("t6_reset_ringing");

        // stop beats setare in RUN; b1 ignored in RUN
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_armed", alarm_on, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_stop_wins", {mode, alarm_on}, {2'b00, 1'b0});
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_b1_ignored", disp_hours, 5'(m_time / 60));

        // random pulses against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 23) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0);
        end

        // reset from wherever random left it, then mid time edit
        async_reset("t6_reset_random");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_editing", dut_outs(), pack(3, 0, 1, 1'b0, 1'b0));
        async_reset("t6_reset_set_time");
        idle(4);
        check("t6_after_reset_run", dut_outs(), pack(0, 1, 0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "time limit");
    end

endmodule
